// File: rtl/countdown_timer_if.sv
// Control and status bundle for the countdown timer: load/start/pause in, count and state flags out.
// The master modport drives the controls; the timer attaches through the slave modport.
interface countdown_timer_if;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic [7:0] number;
  logic       running;
  logic       expired;
  logic       done_pulse;

  modport master (
    output load, load_value, start, pause,
    input  number, running, expired, done_pulse
  );

  modport slave (
    input  load, load_value, start, pause,
    output number, running, expired, done_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// Two-digit seconds countdown timer with load/start/pause control. All outputs are registered,
// so they change one edge after the controls are sampled. There is no backpressure: the controls are sampled every cycle.
module countdown_timer #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int MAX_COUNT   = 99
) (
  input  logic             clk,
  input  logic             resetn,
  countdown_timer_if.slave tmr
);

  localparam int         PW    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] TERM = PW'(CLK_PER_SEC - 1);
  localparam logic [7:0] MAXV  = 8'(MAX_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    number_q, number_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          running_q, expired_q;
  logic          tick;

  // With CLK_PER_SEC=1 TERM is 0, so every RUN cycle is a tick.
  assign tick = (presc_q == TERM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      number_q  <= 8'd0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      number_q  <= number_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
    end
  end

  always_comb begin
    state_d  = state_q;
    number_d = number_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (tmr.load) begin
      number_d = (tmr.load_value > MAXV) ? MAXV : tmr.load_value;
      presc_d  = '0;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tmr.start && (number_q != 8'd0)) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          // Pause beats a coincident tick: the prescaler stays at terminal count.
          if (tmr.pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            presc_d = '0;
            if (number_q <= 8'd1) begin
              number_d = 8'd0;
              state_d  = EXPIRED;
              done_d   = 1'b1;
            end else begin
              number_d = number_q - 8'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSED: begin
          if (!tmr.pause) begin
            state_d = RUN;
          end
        end
        EXPIRED: begin
          number_d = 8'd0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign tmr.number     = number_q;
  assign tmr.running    = running_q;
  assign tmr.expired    = expired_q;
  assign tmr.done_pulse = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer at CLK_PER_SEC=4, MAX_COUNT=99 with hand-computed expectations.
module tb_countdown_timer;
  logic clk;
  logic resetn;
  int   checks;
  int   errors;
  logic [7:0] dcount;

  countdown_timer_if tif();

  countdown_timer #(.CLK_PER_SEC(4), .MAX_COUNT(99)) dut (
    .clk    (clk),
    .resetn (resetn),
    .tmr    (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    dcount = 8'd0;
    resetn = 1'b1;
    tif.load = 1'b0;
    tif.load_value = 8'd0;
    tif.start = 1'b0;
    tif.pause = 1'b0;

    // Reset state, observed before any clock edge
    #2 resetn = 1'b0;
    #1;
    chk8("rst_number", tif.number, 8'd0);
    chk1("rst_running", tif.running, 1'b0);
    chk1("rst_expired", tif.expired, 1'b0);
    chk1("rst_done", tif.done_pulse, 1'b0);
    step(2);
    resetn = 1'b1;
    step(1);
    chk1("release_running", tif.running, 1'b0);
    chk8("release_number", tif.number, 8'd0);

    // Load 3, start, count down to expiry
    tif.load = 1'b1; tif.load_value = 8'd3;
    step(1);
    tif.load = 1'b0; tif.start = 1'b1;
    chk8("load3_number", tif.number, 8'd3);
    chk1("load3_idle", tif.running, 1'b0);
    step(1);
    tif.start = 1'b0;
    chk1("start_running", tif.running, 1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1);
      if (tif.done_pulse === 1'b1) dcount = dcount + 8'd1;
      if (i == 3)  chk8("cnt_hold3", tif.number, 8'd3);
      if (i == 4)  chk8("cnt_2", tif.number, 8'd2);
      if (i == 8)  chk8("cnt_1", tif.number, 8'd1);
      if (i == 11) chk1("done_early", tif.done_pulse, 1'b0);
      if (i == 12) begin
        chk8("cnt_0", tif.number, 8'd0);
        chk1("done_at_0", tif.done_pulse, 1'b1);
        chk1("expired_at_0", tif.expired, 1'b1);
        chk1("running_at_0", tif.running, 1'b0);
      end
    end
    step(1);
    if (tif.done_pulse === 1'b1) dcount = dcount + 8'd1;
    chk1("done_one_cycle", tif.done_pulse, 1'b0);
    chk1("expired_hold", tif.expired, 1'b1);
    chk8("done_count", dcount, 8'd1);

    // Start ignored in EXPIRED, then load 2 leaves it
    tif.start = 1'b1;
    step(1);
    tif.start = 1'b0;
    step(1);
    chk1("exp_start_expired", tif.expired, 1'b1);
    chk1("exp_start_running", tif.running, 1'b0);
    chk8("exp_start_number", tif.number, 8'd0);
    tif.load = 1'b1; tif.load_value = 8'd2;
    step(1);
    tif.load = 1'b0;
    chk1("reload_expired", tif.expired, 1'b0);
    chk8("reload_number", tif.number, 8'd2);
    chk1("reload_running", tif.running, 1'b0);

    // Load above MAX_COUNT is clamped
    tif.load = 1'b1; tif.load_value = 8'd150;
    step(1);
    tif.load = 1'b0; tif.start = 1'b1;
    chk8("clamp_99", tif.number, 8'd99);
    step(1);
    tif.start = 1'b0;
    step(3);
    chk8("clamp_hold", tif.number, 8'd99);
    step(1);
    chk8("clamp_98", tif.number, 8'd98);

    // Load 0 then start stays IDLE with no done pulse
    tif.load = 1'b1; tif.load_value = 8'd0;
    step(1);
    tif.load = 1'b0;
    chk1("load0_running", tif.running, 1'b0);
    tif.start = 1'b1;
    step(1);
    tif.start = 1'b0;
    chk1("zero_start_running", tif.running, 1'b0);
    chk1("zero_start_done", tif.done_pulse, 1'b0);
    step(1);
    chk1("zero_start_done2", tif.done_pulse, 1'b0);

    // Load and start together: load wins
    tif.load = 1'b1; tif.load_value = 8'd7; tif.start = 1'b1;
    step(1);
    tif.load = 1'b0; tif.start = 1'b0;
    chk8("ls_number", tif.number, 8'd7);
    chk1("ls_running", tif.running, 1'b0);
    step(1);
    chk1("ls_running2", tif.running, 1'b0);

    // Pause at terminal count suppresses the tick; resume from held prescaler
    tif.load = 1'b1; tif.load_value = 8'd5;
    step(1);
    tif.load = 1'b0; tif.start = 1'b1;
    step(1);
    tif.start = 1'b0;
    step(3);
    tif.pause = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 1)  chk1("paused_running", tif.running, 1'b0);
      if (i == 10) chk8("paused_number", tif.number, 8'd5);
    end
    tif.pause = 1'b0;
    step(1);
    chk1("resume_running", tif.running, 1'b1);
    chk8("resume_number", tif.number, 8'd5);
    step(1);
    chk8("resume_dec", tif.number, 8'd4);

    // Asynchronous reset mid-count
    tif.load = 1'b1; tif.load_value = 8'd9;
    step(1);
    tif.load = 1'b0; tif.start = 1'b1;
    step(1);
    tif.start = 1'b0;
    step(2);
    #2 resetn = 1'b0;
    #1;
    chk8("arst_number", tif.number, 8'd0);
    chk1("arst_running", tif.running, 1'b0);
    step(1);
    resetn = 1'b1;
    step(1);
    chk1("post_rst_running", tif.running, 1'b0);
    chk8("post_rst_number", tif.number, 8'd0);
    step(4);
    chk1("post_rst_idle", tif.running, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
